// File: rtl/reg_write_if.sv
// Write-path bundle between the two requesters (A: ALU writeback, B: immediate/load)
// and the register-bank write arbiter.
interface reg_write_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic                hold;
    logic                req_a;
    logic [ADDR_W-1:0]   addr_a;
    logic [DATA_W-1:0]   data_a;
    logic                req_b;
    logic [ADDR_W-1:0]   addr_b;
    logic [DATA_W-1:0]   data_b;
    logic                gnt_a;
    logic                gnt_b;
    logic [NUM_REGS-1:0] reg_en;
    logic [DATA_W-1:0]   reg_din;
    logic                busy;

    // Requester / sequencer-control side
    modport master (
        output hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
        input  gnt_a, gnt_b, reg_en, reg_din, busy
    );

    // Arbiter side
    modport slave (
        input  hold, req_a, addr_a, data_a, req_b, addr_b, data_b,
        output gnt_a, gnt_b, reg_en, reg_din, busy
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write-port arbiter for the 4-bit register bank: grants A or B one
// write per cycle, drives a one-hot register enable plus shared write data.
module reg_write_arbiter #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_write_if.slave wr_if
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR_A = 2'd1,
        ST_WR_B = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                last_q, last_d;   // 0: A granted last, 1: B granted last
    logic                gnt_a_q, gnt_a_d;
    logic                gnt_b_q, gnt_b_d;
    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic [DATA_W-1:0]   reg_din_q, reg_din_d;
    logic                busy_q, busy_d;

    function automatic logic [NUM_REGS-1:0] onehot_dec(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] dec;
        dec = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == ADDR_W'(i)) begin
                dec[i] = 1'b1;
            end else begin
                dec[i] = 1'b0;
            end
        end
        return dec;
    endfunction

    // Next-state arbitration; the requester just granted is masked for one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_if.hold) begin
                    state_d = ST_IDLE;
                end else if (wr_if.req_a && wr_if.req_b) begin
                    state_d = last_q ? ST_WR_A : ST_WR_B;
                end else if (wr_if.req_a) begin
                    state_d = ST_WR_A;
                end else if (wr_if.req_b) begin
                    state_d = ST_WR_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_A: begin
                if (wr_if.req_b && !wr_if.hold) begin
                    state_d = ST_WR_B;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_B: begin
                if (wr_if.req_a && !wr_if.hold) begin
                    state_d = ST_WR_A;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output values for the state being entered, so every output is a flop
    always_comb begin
        last_d    = last_q;
        gnt_a_d   = 1'b0;
        gnt_b_d   = 1'b0;
        reg_en_d  = {NUM_REGS{1'b0}};
        reg_din_d = reg_din_q;
        busy_d    = 1'b0;
        case (state_d)
            ST_WR_A: begin
                last_d    = 1'b0;
                gnt_a_d   = 1'b1;
                reg_en_d  = onehot_dec(wr_if.addr_a);
                reg_din_d = wr_if.data_a;
                busy_d    = 1'b1;
            end
            ST_WR_B: begin
                last_d    = 1'b1;
                gnt_b_d   = 1'b1;
                reg_en_d  = onehot_dec(wr_if.addr_b);
                reg_din_d = wr_if.data_b;
                busy_d    = 1'b1;
            end
            ST_IDLE: begin
                reg_din_d = reg_din_q;
            end
            default: begin
                reg_din_d = reg_din_q;
            end
        endcase
    end

    // State and output registers; reset leaves A winning the first contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= 1'b1;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            reg_en_q  <= {NUM_REGS{1'b0}};
            reg_din_q <= {DATA_W{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gnt_a_q   <= gnt_a_d;
            gnt_b_q   <= gnt_b_d;
            reg_en_q  <= reg_en_d;
            reg_din_q <= reg_din_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_if.gnt_a   = gnt_a_q;
    assign wr_if.gnt_b   = gnt_b_q;
    assign wr_if.reg_en  = reg_en_q;
    assign wr_if.reg_din = reg_din_q;
    assign wr_if.busy    = busy_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus a randomized
// run, all compared against a grant/register-bank reference model.
module tb_reg_write_arbiter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    reg_write_if #(.DATA_W(4), .ADDR_W(2)) bus ();

    reg_write_arbiter #(.DATA_W(4), .ADDR_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank fed by the DUT's enables
    logic [3:0] bank_q [4];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.reg_en[i]) bank_q[i] <= bus.reg_din;
        end
    end

    // Reference model: who owns the write cycle in progress (0 none, 1 A, 2 B)
    int         m_gnt;
    bit         m_last;      // 0: A granted last, 1: B granted last
    logic [1:0] m_addr;
    logic [3:0] m_din;
    logic [3:0] m_bank [4];

    function automatic void m_reset();
        m_gnt  = 0;
        m_last = 1'b1;
        m_din  = 4'h0;
        m_addr = 2'd0;
    endfunction

    function automatic void m_edge();
        bit a_ok, b_ok;
        int pick;
        if (m_gnt != 0) m_bank[m_addr] = m_din;
        a_ok = bus.req_a && !bus.hold && (m_gnt != 1);
        b_ok = bus.req_b && !bus.hold && (m_gnt != 2);
        if (a_ok && b_ok) pick = m_last ? 1 : 2;
        else if (a_ok)    pick = 1;
        else if (b_ok)    pick = 2;
        else              pick = 0;
        if (pick == 1) begin
            m_addr = bus.addr_a; m_din = bus.data_a; m_last = 1'b0;
        end else if (pick == 2) begin
            m_addr = bus.addr_b; m_din = bus.data_b; m_last = 1'b1;
        end
        m_gnt = pick;
    endfunction

    function automatic logic [10:0] exp_vec();
        logic [3:0] en;
        en = (m_gnt != 0) ? (4'b0001 << m_addr) : 4'b0000;
        return {m_gnt == 1, m_gnt == 2, en, m_din, m_gnt != 0};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.gnt_a, bus.gnt_b, bus.reg_en, bus.reg_din, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic go_idle();
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.hold = 1'b0;
        tick(); tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.hold = 1'b0; bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.addr_a = 2'd0; bus.data_a = 4'h0; bus.addr_b = 2'd0; bus.data_b = 4'h0;
        m_reset();
        #3;
        n_checks++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_init: got %h expected %h", dut_vec(), 11'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_a = 1'b1; bus.addr_a = 2'd3; bus.data_a = 4'h5;
        tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_pre_wr_a: got %h expected %h", dut_vec(), exp_vec());
        end
        rst_n = 1'b0;
        #1;
        m_reset();
        n_checks++;
        if (dut_vec() !== 11'd0) begin
            n_fail++; $display("FAIL reset_mid_write: got %h expected %h", dut_vec(), 11'd0);
        end
        bus.req_a = 1'b1; bus.addr_a = 2'd3; bus.data_a = 4'hA;
        bus.req_b = 1'b1; bus.addr_b = 2'd0; bus.data_b = 4'h6;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.gnt_a, bus.gnt_b, bus.reg_en, bus.reg_din} !== {1'b1, 1'b0, 4'b1000, 4'hA}) begin
            n_fail++; $display("FAIL reset_first_grant_a: got %b%b %b %h expected 10 1000 a",
                               bus.gnt_a, bus.gnt_b, bus.reg_en, bus.reg_din);
        end
        go_idle();
    endtask

    task automatic test_single_a();
        go_idle();
        bus.req_a = 1'b1; bus.addr_a = 2'd2; bus.data_a = 4'hC;
        tick();
        bus.req_a = 1'b0;
        n_checks++;
        if (dut_vec() !== {1'b1, 1'b0, 4'b0100, 4'hC, 1'b1}) begin
            n_fail++; $display("FAIL single_a_write: got %h expected %h", dut_vec(), {1'b1, 1'b0, 4'b0100, 4'hC, 1'b1});
        end
        tick();
        n_checks++;
        if (dut_vec() !== {1'b0, 1'b0, 4'b0000, 4'hC, 1'b0}) begin
            n_fail++; $display("FAIL single_a_idle: got %h expected %h", dut_vec(), {1'b0, 1'b0, 4'b0000, 4'hC, 1'b0});
        end
    endtask

    task automatic test_contention();
        go_idle();
        do_reset();
        bus.req_a = 1'b1; bus.addr_a = 2'd0; bus.data_a = 4'($urandom);
        bus.req_b = 1'b1; bus.addr_b = 2'd3; bus.data_b = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL contention_model[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            n_checks++;
            if ({bus.gnt_a, bus.gnt_b} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL contention_order[%0d]: got %b expected %b", i,
                                   {bus.gnt_a, bus.gnt_b}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (bus.gnt_a) bus.data_a = 4'($urandom);
            if (bus.gnt_b) bus.data_b = 4'($urandom);
        end
        go_idle();
    endtask

    task automatic test_stream_b();
        go_idle();
        bus.req_b = 1'b1; bus.addr_b = 2'($urandom); bus.data_b = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL stream_b_model[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            n_checks++;
            if (bus.gnt_b !== ((i % 2 == 0) ? 1'b1 : 1'b0) || (bus.reg_en != 4'b0000) !== bus.gnt_b) begin
                n_fail++; $display("FAIL stream_b_pattern[%0d]: got gnt_b=%b reg_en=%b expected gnt_b=%b",
                                   i, bus.gnt_b, bus.reg_en, (i % 2 == 0));
            end
            if (bus.gnt_b) begin
                bus.addr_b = 2'($urandom); bus.data_b = 4'($urandom);
            end
        end
        go_idle();
    endtask

    task automatic test_hold();
        go_idle();
        bus.req_a = 1'b1; bus.addr_a = 2'd1; bus.data_a = 4'h7;
        tick();
        n_checks++;
        if ({bus.gnt_a, bus.busy} !== 2'b11) begin
            n_fail++; $display("FAIL hold_wr_a: got gnt_a=%b busy=%b expected 1 1", bus.gnt_a, bus.busy);
        end
        bus.req_a = 1'b0; bus.hold = 1'b1;
        bus.req_b = 1'b1; bus.addr_b = 2'd2; bus.data_b = 4'hE;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== {1'b0, 1'b0, 4'b0000, 4'h7, 1'b0} || dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL hold_idle[%0d]: got %h expected %h", i, dut_vec(), {1'b0, 1'b0, 4'b0000, 4'h7, 1'b0});
            end
        end
        bus.hold = 1'b0;
        tick();
        n_checks++;
        if (dut_vec() !== {1'b0, 1'b1, 4'b0100, 4'hE, 1'b1}) begin
            n_fail++; $display("FAIL hold_release_b: got %h expected %h", dut_vec(), {1'b0, 1'b1, 4'b0100, 4'hE, 1'b1});
        end
        go_idle();
    endtask

    task automatic test_same_addr();
        go_idle();
        do_reset();
        bus.req_a = 1'b1; bus.addr_a = 2'd1; bus.data_a = 4'h3;
        bus.req_b = 1'b1; bus.addr_b = 2'd1; bus.data_b = 4'h9;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.gnt_a) bus.req_a = 1'b0;
            if (bus.gnt_b) bus.req_b = 1'b0;
            n_checks++;
            if (dut_vec() !== exp_vec() || (bus.busy ? !$onehot(bus.reg_en) : (bus.reg_en != 4'b0000))) begin
                n_fail++; $display("FAIL same_addr_cycle[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bank_q[1] !== 4'h9 || m_bank[1] !== 4'h9) begin
            n_fail++; $display("FAIL same_addr_final: got reg1=%h expected 9", bank_q[1]);
        end
    endtask

    task automatic test_random();
        go_idle();
        for (int i = 0; i < 400; i++) begin
            if (!(bus.req_a && !bus.gnt_a && $urandom_range(0, 15) != 0)) begin
                bus.req_a = 1'($urandom_range(0, 1));
                bus.addr_a = 2'($urandom); bus.data_a = 4'($urandom);
            end
            if (!(bus.req_b && !bus.gnt_b && $urandom_range(0, 15) != 0)) begin
                bus.req_b = 1'($urandom_range(0, 1));
                bus.addr_b = 2'($urandom); bus.data_b = 4'($urandom);
            end
            bus.hold = ($urandom_range(0, 7) == 0);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_model[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            n_checks++;
            if ((bus.gnt_a && bus.gnt_b) || (bus.busy ? !$onehot(bus.reg_en) : (bus.reg_en != 4'b0000))) begin
                n_fail++; $display("FAIL random_invariant[%0d]: got gnt=%b%b reg_en=%b busy=%b expected exclusive one-hot",
                                   i, bus.gnt_a, bus.gnt_b, bus.reg_en, bus.busy);
            end
        end
        go_idle();
        for (int r = 0; r < 4; r++) begin
            n_checks++;
            if (bank_q[r] !== m_bank[r]) begin
                n_fail++; $display("FAIL random_bank[%0d]: got %h expected %h", r, bank_q[r], m_bank[r]);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int r = 0; r < 4; r++) begin
            bank_q[r] = 4'h0;
            m_bank[r] = 4'h0;
        end
        test_reset();
        test_single_a();
        test_contention();
        test_stream_b();
        test_hold();
        test_same_addr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Write-port arbiter and sequencer for the processor's bank of 4-bit parallel registers. Two requesters share the bank's write path: requester A is ALU writeback and requester B is immediate/load. The block grants one request per write cycle with round-robin fairness. It drives a one-hot per-register enable and the write data, so exactly one register captures per granted cycle.

## Interface
- DATA_W, 4, register data width; matches the 4-bit parallel registers.
- ADDR_W, 2, register address width; bank size NUM_REGS = 2**ADDR_W.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  when high, no new grant is issued; a write already in flight completes.
- req_a  in  1  requester A write request; held until gnt_a.
- addr_a  in  ADDR_W  requester A target register.
- data_a  in  DATA_W  requester A write data.
- req_b, addr_b, data_b  in  1/ADDR_W/DATA_W  same as A, for requester B.
- gnt_a  out  1  one-cycle pulse: A's write is occurring this cycle.
- gnt_b  out  1  one-cycle pulse: B's write is occurring this cycle.
- reg_en  out  NUM_REGS  one-hot enable to the register bank (bit i drives register i's enable).
- reg_din  out  DATA_W  write data, common to all registers.
- busy  out  1  high while in a write state.

## Operation
- States: IDLE, WR_A, WR_B. All outputs are registered.
- The last-grant pointer `last` is one bit: 0 means A was granted last, 1 means B was granted last.
- The arbitration decision is made at each rising edge from the current state and the sampled inputs.
- From IDLE, with hold=0:
  - Only req_a high -> WR_A.
  - Only req_b high -> WR_B.
  - Both high -> grant the requester not in `last`.
  - Neither high -> stay in IDLE.
- From IDLE with hold=1: stay in IDLE regardless of requests.
- From WR_A: req_a is masked. With req_b=1 and hold=0 -> WR_B; otherwise -> IDLE.
- From WR_B: req_b is masked. With req_a=1 and hold=0 -> WR_A; otherwise -> IDLE.
- A requester therefore never receives two consecutive grants; it gets at most one grant per two cycles.
- On entering WR_x:
  - Latch addr_x and data_x.
  - reg_en = 1 << addr_x; reg_din = data_x.
  - gnt_x = 1; busy = 1.
  - `last` is updated to x.
- On entering IDLE:
  - reg_en = 0, gnt_a = 0, gnt_b = 0, busy = 0.
  - reg_din holds its last value.
- Requester rule: req_x, addr_x and data_x stay stable from assertion until the cycle in which gnt_x is high. req_x may drop or re-assert on the next cycle.
- A request withdrawn before it is granted is simply never granted. This is legal; no error is flagged.
- Simultaneous requests to the same address from A and B are serialized in round-robin order. The later write wins in the register.
- Every address in 0..NUM_REGS-1 is valid; no out-of-range case exists.
- Asynchronous reset (rst_n=0) takes effect immediately, including mid-write:
  - State -> IDLE, `last` -> 1 (A wins the first contention).
  - gnt_a, gnt_b, busy, reg_en and reg_din all 0.
  - No partial write is emitted after reset release.

## Timing
- Request latency: req_x sampled high at edge k (state IDLE, hold=0, request wins). gnt_x, reg_en and reg_din are valid during cycle k..k+1, and the target register captures at edge k+1.
- Back-to-back alternation: with A and B both requesting continuously, writes go A, B, A, B, ... with no idle cycle between grants.
- Single requester held high continuously is granted every other cycle (WR_x, IDLE, WR_x, ...).
- hold asserted during WR_x: the current write completes and the next state is IDLE. hold is honored at the following edge.
- Exactly one reg_en bit is high when busy=1; reg_en is all zeros when busy=0.
- gnt_a and gnt_b are never high in the same cycle.

## Test plan
- Reset: drive rst_n=0 mid-WR_A. All outputs go to 0 immediately. After release with req_a=req_b=1, the first grant goes to A.
- Single A write: req_a=1, addr_a=2, data_a=4'hC for one edge. Next cycle gnt_a=1, reg_en=4'b0100, reg_din=4'hC. The cycle after that, reg_en=0 and busy=0.
- Contention: req_a and req_b held high for 6 cycles with distinct addresses. Grant sequence is A, B, A, B, A, B. gnt_a and gnt_b are never both high, and there are no idle cycles.
- Single requester streaming: req_b held high for 6 cycles. gnt_b pattern is 1, 0, 1, 0, 1, 0 and reg_en toggles accordingly.
- Hold: assert hold in cycle WR_A with req_b pending. WR_A completes, state goes to IDLE, and no gnt_b appears while hold=1. gnt_b appears 1 cycle after hold drops.
- Same-address race: A writes 4'h3 and B writes 4'h9 to register 1, starting from a reset pointer. Register 1 ends holding 4'h9. The scoreboard confirms one-hot reg_en on every busy cycle.
